// File: rtl/move_encoder_if.sv
// Location-in / direction-out bus of the path replay encoder.
// master: path source and direction consumer; slave: move_encoder.
interface move_encoder_if;
    logic [7:0] locIn;
    logic       locValid;
    logic       locLast;
    logic       locReady;
    logic [1:0] dirOut;
    logic       dirValid;
    logic       dirReady;
    logic [7:0] moveCnt;
    logic       finished;
    logic       err;

    modport master (
        output locIn, locValid, locLast, dirReady,
        input  locReady, dirOut, dirValid, moveCnt, finished, err
    );

    modport slave (
        input  locIn, locValid, locLast, dirReady,
        output locReady, dirOut, dirValid, moveCnt, finished, err
    );
endinterface

// File: rtl/move_encoder.sv
// Converts consecutive solved-path locations {X[7:4], Y[3:0]} into 2-bit
// direction codes (00 Y-1, 01 X+1, 10 X-1, 11 Y+1), buffers them in a
// show-ahead FIFO and flags non-adjacent steps as a sticky error.
module move_encoder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic clk,
    input  logic rst,
    move_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        DRAIN,
        FINISH,
        ERROR
    } state_t;

    state_t        state, stateNx;
    logic [7:0]    prevLoc;
    logic [7:0]    moveCnt;
    logic [1:0]    mem [DEPTH];
    logic [AW:0]   wrPtr, rdPtr;
    logic          empty, full;
    logic          locReady;
    logic          accept, push, pop, capture;
    logic          legal;
    logic [1:0]    code;
    logic [4:0]    xNew, xOld, yNew, yOld;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign locReady = ((state == IDLE) || (state == TRACK)) && !full;
    assign accept   = bus.locValid && locReady;
    assign pop      = !empty && bus.dirReady;

    // Coordinates widened by one bit so a 15<->0 step never looks adjacent.
    assign xNew = {1'b0, bus.locIn[7:4]};
    assign yNew = {1'b0, bus.locIn[3:0]};
    assign xOld = {1'b0, prevLoc[7:4]};
    assign yOld = {1'b0, prevLoc[3:0]};

    // Classify the offered location against prevLoc as one unit step or illegal.
    always_comb begin
        legal = 1'b0;
        code  = 2'b00;
        if (yNew == yOld) begin
            if (xNew == xOld + 5'd1) begin
                legal = 1'b1;
                code  = 2'b01;
            end else if (xNew + 5'd1 == xOld) begin
                legal = 1'b1;
                code  = 2'b10;
            end
        end else if (xNew == xOld) begin
            if (yNew == yOld + 5'd1) begin
                legal = 1'b1;
                code  = 2'b11;
            end else if (yNew + 5'd1 == yOld) begin
                legal = 1'b1;
                code  = 2'b00;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNx;
        end
    end

    // Next-state decode plus push / prevLoc-capture strobes.
    always_comb begin
        stateNx = state;
        push    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.locIn == 8'h00) begin
                        capture = 1'b1;
                        stateNx = bus.locLast ? DRAIN : TRACK;
                    end else begin
                        stateNx = ERROR;
                    end
                end
            end
            TRACK: begin
                if (accept) begin
                    if (legal) begin
                        push    = 1'b1;
                        capture = 1'b1;
                        if (bus.locLast) begin
                            stateNx = DRAIN;
                        end
                    end else begin
                        stateNx = ERROR;
                    end
                end
            end
            DRAIN: begin
                if (empty) begin
                    stateNx = FINISH;
                end
            end
            FINISH:  stateNx = FINISH;
            ERROR:   stateNx = ERROR;
            default: stateNx = ERROR;
        endcase
    end

    // Last accepted location and saturating count of pushed codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevLoc <= '0;
            moveCnt <= '0;
        end else begin
            if (capture) begin
                prevLoc <= bus.locIn;
            end
            if (push && (moveCnt != 8'hFF)) begin
                moveCnt <= moveCnt + 8'd1;
            end
        end
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + (AW+1)'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= code;
        end
    end

    assign bus.locReady = locReady;
    assign bus.dirValid = !empty;
    assign bus.dirOut   = empty ? 2'b00 : mem[rdPtr[AW-1:0]];
    assign bus.moveCnt  = moveCnt;
    assign bus.finished = (state == FINISH);
    assign bus.err      = (state == ERROR);

endmodule

// File: tb/tb_move_encoder.sv
// Directed bench for move_encoder: path encoding, back-pressure, errors,
// zero-move path and asynchronous reset.
module tb_move_encoder;

    logic clk;
    logic rst;
    int unsigned passed;
    int unsigned total;
    logic [1:0] captured[$];
    logic [1:0] expq[$];
    logic       sawValid;

    move_encoder_if bus();

    move_encoder #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every code the consumer takes; the pop happens on the next rising edge.
    always @(negedge clk) begin
        if (bus.dirValid) sawValid <= 1'b1;
        if (!rst && bus.dirValid && bus.dirReady) captured.push_back(bus.dirOut);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offer one location and hold it until accepted (bounded); returns at posedge+1.
    task automatic send(input logic [7:0] loc, input logic last);
        int unsigned n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.locIn    = loc;
        bus.locLast  = last;
        bus.locValid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.locReady) ok = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
        bus.locValid = 1'b0;
        bus.locLast  = 1'b0;
        check("send_accept", {7'b0, ok}, 8'h01);
    endtask

    task automatic wait_finished();
        int unsigned n;
        n = 0;
        while (!bus.finished && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("finished", {7'b0, bus.finished}, 8'h01);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        captured.delete();
        sawValid = 1'b0;
    endtask

    task automatic check_codes(input string tag);
        check({tag, "_count"}, 8'(captured.size()), 8'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            check(tag, {6'b0, (i < captured.size()) ? captured[i] : 2'bxx}, {6'b0, expq[i]});
        end
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        sawValid     = 1'b0;
        rst          = 1'b1;
        bus.locIn    = 8'h00;
        bus.locValid = 1'b0;
        bus.locLast  = 1'b0;
        bus.dirReady = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_dirValid", {7'b0, bus.dirValid}, 8'h00);
        check("rst_dirOut",   {6'b0, bus.dirOut},   8'h00);
        check("rst_locReady", {7'b0, bus.locReady}, 8'h01);
        check("rst_moveCnt",  bus.moveCnt,          8'h00);
        check("rst_finished", {7'b0, bus.finished}, 8'h00);
        check("rst_err",      {7'b0, bus.err},      8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic path 00,10,11,21,22
        do_reset();
        bus.dirReady = 1'b1;
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h21, 1'b0);
        send(8'h22, 1'b1);
        wait_finished();
        expq = '{2'b01, 2'b11, 2'b01, 2'b11};
        check_codes("basic_code");
        check("basic_moveCnt", bus.moveCnt,          8'h04);
        check("basic_err",     {7'b0, bus.err},      8'h00);

        // All four directions 00,01,11,10,00
        do_reset();
        bus.dirReady = 1'b1;
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h11, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b1);
        wait_finished();
        expq = '{2'b11, 2'b01, 2'b00, 2'b10};
        check_codes("alldir_code");
        check("alldir_moveCnt", bus.moveCnt, 8'h04);

        // Back-pressure: 17 steps with the consumer stalled
        do_reset();
        bus.dirReady = 1'b0;
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        @(negedge clk);
        check("lat_dirValid", {7'b0, bus.dirValid}, 8'h01);
        check("lat_dirOut",   {6'b0, bus.dirOut},   8'h01);
        @(posedge clk);
        #1;
        for (int unsigned i = 2; i < 16; i++) send({4'(i), 4'h0}, 1'b0);
        send(8'hF1, 1'b0);
        @(negedge clk);
        check("bp_full_locReady", {7'b0, bus.locReady}, 8'h00);
        check("bp_full_moveCnt",  bus.moveCnt,          8'h10);
        bus.locIn    = 8'hF2;
        bus.locLast  = 1'b1;
        bus.locValid = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_held_moveCnt", bus.moveCnt, 8'h10);
        @(posedge clk);
        #1;
        bus.dirReady = 1'b1;
        @(negedge clk);
        check("bp_pop_when_full_locReady", {7'b0, bus.locReady}, 8'h00);
        begin
            int unsigned n;
            n = 0;
            while (!bus.locReady && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("bp_resume_locReady", {7'b0, bus.locReady}, 8'h01);
        end
        @(posedge clk);
        #1;
        bus.locValid = 1'b0;
        bus.locLast  = 1'b0;
        wait_finished();
        check("bp_moveCnt", bus.moveCnt, 8'h11);
        expq.delete();
        repeat (15) expq.push_back(2'b01);
        repeat (2) expq.push_back(2'b11);
        check_codes("bp_code");

        // Error: first location not the origin
        do_reset();
        send(8'h05, 1'b0);
        @(negedge clk);
        check("err05_err",      {7'b0, bus.err},      8'h01);
        check("err05_locReady", {7'b0, bus.locReady}, 8'h00);

        // Error: two-cell jump, nothing pushed
        do_reset();
        bus.dirReady = 1'b1;
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        @(negedge clk);
        check("err02_err",      {7'b0, bus.err},      8'h01);
        check("err02_moveCnt",  bus.moveCnt,          8'h00);
        check("err02_dirValid", {7'b0, bus.dirValid}, 8'h00);
        check("err02_sawValid", {7'b0, sawValid},     8'h00);

        // Error: Y wrap 0 -> 15
        do_reset();
        send(8'h00, 1'b0);
        send(8'h0F, 1'b0);
        @(negedge clk);
        check("errYwrap_err",     {7'b0, bus.err}, 8'h01);
        check("errYwrap_moveCnt", bus.moveCnt,     8'h00);

        // Error: X wrap 0 -> 15
        do_reset();
        send(8'h00, 1'b0);
        send(8'hF0, 1'b0);
        @(negedge clk);
        check("errXwrap_err", {7'b0, bus.err}, 8'h01);

        // Error after one legal step: queued code still drains
        do_reset();
        bus.dirReady = 1'b0;
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        @(negedge clk);
        check("errdrain_err",      {7'b0, bus.err},      8'h01);
        check("errdrain_moveCnt",  bus.moveCnt,          8'h01);
        check("errdrain_dirValid", {7'b0, bus.dirValid}, 8'h01);
        @(posedge clk);
        #1;
        bus.dirReady = 1'b1;
        repeat (3) @(negedge clk);
        check("errdrain_empty", {7'b0, bus.dirValid}, 8'h00);
        check("errdrain_sticky", {7'b0, bus.err},     8'h01);
        expq = '{2'b11};
        check_codes("errdrain_code");

        // Zero-move path
        do_reset();
        bus.dirReady = 1'b1;
        send(8'h00, 1'b1);
        @(negedge clk);
        check("zero_finished_n1", {7'b0, bus.finished}, 8'h00);
        @(negedge clk);
        check("zero_finished_n2", {7'b0, bus.finished}, 8'h01);
        check("zero_moveCnt",     bus.moveCnt,          8'h00);
        check("zero_sawValid",    {7'b0, sawValid},     8'h00);
        @(posedge clk);
        #1;

        // Reset with 5 codes queued, then a fresh path
        do_reset();
        bus.dirReady = 1'b0;
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        send(8'h50, 1'b0);
        @(negedge clk);
        check("mid_moveCnt_pre", bus.moveCnt, 8'h05);
        #2;
        rst = 1'b1;
        #1;
        check("mid_dirValid", {7'b0, bus.dirValid}, 8'h00);
        check("mid_moveCnt",  bus.moveCnt,          8'h00);
        check("mid_locReady", {7'b0, bus.locReady}, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b0;
        captured.delete();
        bus.dirReady = 1'b1;
        send(8'h00, 1'b0);
        send(8'h10, 1'b1);
        wait_finished();
        expq = '{2'b01};
        check_codes("mid_fresh_code");
        check("mid_fresh_moveCnt", bus.moveCnt, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/move_encoder.md
# move_encoder

Downstream consumer of the maze-solver datapath's path replay. During the run phase, the datapath's stack queue emits the solved path one location at a time on `move`, each as {X[7:4], Y[3:0]}. This block converts each pair of consecutive locations into the 2-bit direction code the datapath uses and buffers the codes in a FIFO. It then hands them to the output or display stage over a valid/ready handshake, and flags any non-adjacent step as an error.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- AW, 4: log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- locIn  in  8  path location, {X[7:4], Y[3:0]}.
- locValid  in  1  `locIn` is valid this cycle.
- locLast  in  1  qualifies `locIn`; marks the final location (the goal).
- locReady  out  1  block accepts `locIn` this cycle.
- dirOut  out  2  direction code at the FIFO head.
- dirValid  out  1  FIFO not empty.
- dirReady  in  1  consumer takes `dirOut` this cycle.
- moveCnt  out  8  number of direction codes pushed; saturates at 255.
- finished  out  1  last location accepted and FIFO drained.
- err  out  1  sticky protocol/path error.

## Operation
- Direction codes, identical to the datapath's `dir`:
  - 00 = Y-1
  - 01 = X+1
  - 10 = X-1
  - 11 = Y+1
- States: IDLE, TRACK, DRAIN, FINISH, ERROR.
- IDLE: waits for the first accepted location.
  - `locIn` = 8'h00: store it in `prevLoc` and go to TRACK. No code is pushed.
  - Any other value: go to ERROR.
  - First location with `locLast` = 1 and value 8'h00: go directly to DRAIN (zero-move path).
- TRACK, on each accepted location:
  - dX = locIn[7:4] - prevLoc[7:4] and dY = locIn[3:0] - prevLoc[3:0], both 4-bit, compared as exact values.
  - Legal step: exactly one of dX, dY is 4'h1 or 4'hF and the other is 0. Wrap-around (X 15 to 0, or 0 to 15) is illegal: decide legality on the unsigned coordinates, not the modular difference.
  - Legal step: push the code, update `prevLoc`, increment `moveCnt`.
  - If `locLast` is also set on a legal step: go to DRAIN.
  - Illegal step, including a repeated location: go to ERROR. Nothing is pushed and `prevLoc` is unchanged.
- DRAIN: `locReady` = 0. Go to FINISH when the FIFO is empty.
- FINISH: `finished` = 1. Held until `rst`.
- ERROR: `err` = 1 and `locReady` = 0. Codes already in the FIFO still drain. Only `rst` exits this state.
- FIFO: show-ahead.
  - `dirOut` = mem[rdPtr]; `dirValid` = !empty.
  - Pop on `dirValid` && `dirReady`.
  - Pointers are AW+1 bits wide; full/empty are determined by the MSB comparison.
- Back-pressure: `locReady` = (state IDLE or TRACK) && !full.
  - `locReady` is combinational from state and the FIFO flags only.
  - When full, `locReady` stays 0 even if a pop occurs in the same cycle.

## Timing
- Reset values:
  - state = IDLE, FIFO empty, `prevLoc` = 8'h00, `moveCnt` = 0.
  - `dirOut` = 2'b00 (don't-care while `dirValid` = 0).
  - `dirValid` = 0, `finished` = 0, `err` = 0, `locReady` = 1.
- Latency: a location accepted at edge N makes `dirValid` = 1 after edge N, i.e. during cycle N+1 (one cycle).
- Push and pop in the same cycle when not full and not empty: occupancy unchanged, order preserved.
- `moveCnt` updates on the same edge as the push.
- `finished` rises one cycle after the edge that empties the FIFO in DRAIN.
- `err` rises on the edge that accepts the illegal location.
- Reset mid-operation: everything returns to reset values asynchronously; FIFO contents are discarded.
- `locLast` is ignored when `locValid` = 0.

## Test plan
- Basic path: locations 00, 10, 11, 21, 22(last) with `dirReady` = 1.
  - Required: `dirOut` sequence 01, 11, 01, 11.
  - Required: `moveCnt` = 4 and `finished` = 1; `err` = 0.
- All directions: 00, 01, 11, 10, 00(last).
  - Required: codes 11, 01, 00, 10.
- Back-pressure: `dirReady` = 0 while 17 legal steps are offered.
  - Required: `locReady` drops after 16 pushes; the 17th location is held and not lost.
  - Then raise `dirReady`: all 17 codes come out in order.
- Errors:
  - First location 8'h05: `err` = 1 and `locReady` = 0.
  - Path 00, 02: `err` = 1 and nothing pushed.
  - Path 00, 0F (Y wrap): `err` = 1.
- Zero-move path: first location 00 with `locLast`.
  - Required: `finished` = 1 two cycles later, `moveCnt` = 0, `dirValid` never 1.
- Reset mid-stream: assert `rst` with 5 codes queued.
  - Required: `dirValid` = 0, `moveCnt` = 0, `locReady` = 1 immediately.
  - Then a fresh path 00, 10(last) yields a single code 01.
